queue2_wr_arb: RTL
==================

// Module: queue2_wr_arb
// PURPOSE
//  Round-robin arbiter sharing the write port of one queue2 (2-entry FIFO) among NREQ requesters.
//  Supports multi-beat packets: a requester keeps the grant until its beat marked "last" is accepted.
//  Sits between packet producers and the queue2 write port; o_q_wr is never asserted while i_q_full=1.
// PARAMETERS
//  WIDTH      32  data width per beat (matches queue2 WIDTH)
//  NREQ       4   number of requesters, 2..8
//  MAX_BURST  8   max beats per lock; forced release after the MAX_BURST-th accepted beat
//  TIMEOUT    16  idle cycles before a stalled lock is dropped (TIMEOUT build option only)
// PORTS
//  i_clk        in   1            clock
//  i_rst_n      in   1            async active-low reset
//  i_req        in   NREQ         per-requester beat valid
//  i_req_last   in   NREQ         per-requester last-beat flag, qualified by i_req
//  i_req_data   in   NREQ*WIDTH   beat data, requester k at [k*WIDTH +: WIDTH]
//  o_gnt        out  NREQ         one-hot: beat of requester k accepted this cycle
//  o_q_wr       out  1            queue2 i_wr
//  o_q_wr_data  out  WIDTH        queue2 i_wr_data
//  i_q_full     in   1            queue2 o_full
//  o_busy       out  1            a packet lock is held
//  o_owner      out  3            index of lock holder, or last winner when idle
//  o_timeout    out  1            1-cycle pulse: lock dropped by timeout (TIMEOUT build option only, else 0)
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state IDLE, rr pointer=0, beat count=0, o_owner=0, o_busy=0.
//   o_q_wr, o_gnt gated low while i_rst_n=0.
//  States: IDLE, LOCK. Grant path is combinational from registered state; 0-cycle accept latency.
//  IDLE: winner = first k with i_req[k], searching ptr, ptr+1, ... mod NREQ.
//   If a winner exists and !i_q_full: o_q_wr=1, o_q_wr_data=winner data, o_gnt[winner]=1, o_owner<=winner.
//   Accepted beat with last=1: stay IDLE, ptr<=winner+1 mod NREQ.
//   Accepted beat with last=0: -> LOCK, count<=1.
//   i_q_full=1: no write, no gnt, ptr unchanged; the winner is re-evaluated next cycle (no reservation).
//  LOCK: only o_owner is served; requests from all others are ignored.
//   o_q_wr = i_req[owner] && !i_q_full; each accept increments count.
//   Release -> IDLE, ptr<=owner+1 on any of:
//    - accepted beat has last=1;
//    - count reaches MAX_BURST (that beat accepted normally, its last ignored).
//  o_busy = (state==LOCK).
//  Queue full and empty:
//   - never write when i_q_full=1;
//   - a simultaneous queue2 read does not unblock the same cycle (full is sampled as given);
//   - the arbiter has no read-side dependency.
//  Pointer wraps NREQ-1 -> 0.
//  Count width = clog2(MAX_BURST+1); it saturates by release, so it never overflows.
//  Reset mid-packet: lock lost, queue2 keeps the partial packet; the producer must restart.
// CONFIGURATION
//  QUEUE2_ARB_TIMEOUT_EN defined:
//   - in LOCK, an idle counter increments each cycle with i_req[owner]=0 and clears on an owner request.
//   - when the counter reaches TIMEOUT: -> IDLE, ptr<=owner+1, o_timeout pulses 1 cycle.
//   - i_q_full stalls do not count.
//  Undefined: no idle counter; LOCK is held indefinitely while the owner is idle; o_timeout tied 0.
// TESTING  (NREQ=4, WIDTH=32, MAX_BURST=8, TIMEOUT=16)
//  1. Fairness.
//   - Stimulus: req=4'b1111, all last=1, full=0 for 8 cycles.
//   - Expected: gnt sequence 0,1,2,3,0,1,2,3; data follows the granted port.
//  2. Packet lock.
//   - Stimulus: req0 sends a 3-beat packet (last on beat 3) while req1=1 throughout.
//   - Expected: gnt0 x3, then gnt1; o_busy=1 for cycles 2-3 only.
//  3. Backpressure.
//   - Stimulus: full=1 for 5 cycles with req2=1.
//   - Expected: o_q_wr=0, gnt=0 throughout; first accept in the cycle full drops.
//   - Expected: no beat lost or duplicated against a queue2 model.
//  4. Burst cap.
//   - Stimulus: req3 streams 12 beats with last=0.
//   - Expected: 8 accepted, then release to IDLE; pending req0 granted next.
//  5. Async reset in LOCK.
//   - Stimulus: drop i_rst_n between clock edges.
//   - Expected: o_q_wr and o_gnt go 0 immediately; after release o_busy=0, first grant goes to req0.
//  6. Timeout (macro defined).
//   - Stimulus: owner idles 16 cycles.
//   - Expected: o_timeout pulses once, o_busy=0, and another requester is granted on the next cycle.
//   - Macro undefined: lock is held and o_timeout stays 0.

Source files
------------

// File: rtl/queue2_wr_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : queue2_wr_arb_if
// Purpose  : Requester-side and queue2-write-side bundle of the queue2 arbiter.
// Revision : 1.0
// ============================================================================
interface queue2_wr_arb_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       i_req;
    logic [NREQ-1:0]       i_req_last;
    logic [NREQ*WIDTH-1:0] i_req_data;
    logic [NREQ-1:0]       o_gnt;
    logic                  o_q_wr;
    logic [WIDTH-1:0]      o_q_wr_data;
    logic                  i_q_full;
    logic                  o_busy;
    logic [2:0]            o_owner;
    logic                  o_timeout;

    modport slave (
        input  i_req, i_req_last, i_req_data, i_q_full,
        output o_gnt, o_q_wr, o_q_wr_data, o_busy, o_owner, o_timeout
    );

    modport master (
        output i_req, i_req_last, i_req_data, i_q_full,
        input  o_gnt, o_q_wr, o_q_wr_data, o_busy, o_owner, o_timeout
    );
endinterface

`default_nettype wire

// File: rtl/queue2_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : queue2_wr_arb
// Purpose  : Round-robin, packet-locking arbiter for the queue2 write port.
//            Build option QUEUE2_ARB_TIMEOUT_EN drops idle locks after TIMEOUT.
// Revision : 1.0
// ============================================================================
module queue2_wr_arb #(
    parameter int WIDTH     = 32,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 8,
    parameter int TIMEOUT   = 16
) (
    input  wire logic      i_clk,
    input  wire logic      i_rst_n,
    queue2_wr_arb_if.slave bus
);

    localparam int c_CW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    generate
        if (NREQ < 2 || NREQ > 8 || MAX_BURST < 1 || TIMEOUT < 1) begin : g_param_check
            $error("queue2_wr_arb: parameter out of range");
        end
    endgenerate

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_ptr;
    logic [2:0]        w_ptr_nxt;
    logic [2:0]        r_owner;
    logic [2:0]        w_owner_nxt;
    logic [c_CW-1:0]   r_cnt;
    logic [c_CW-1:0]   w_cnt_nxt;

    logic              w_found;
    logic [2:0]        w_win;
    logic              w_win_last;
    logic              w_own_req;
    logic              w_own_last;
    logic [2:0]        w_sel;
    logic              w_wr;
    logic [NREQ-1:0]   w_gnt;
    logic [WIDTH-1:0]  w_data;
    int                w_dist;
    int                w_best;

`ifdef QUEUE2_ARB_TIMEOUT_EN
    localparam int c_TW = $clog2(TIMEOUT + 1);
    logic [c_TW-1:0]   r_idle;
    logic [c_TW-1:0]   w_idle_nxt;
    logic              r_tmo;
    logic              w_tmo_nxt;
`endif

    function automatic logic [2:0] f_inc(input logic [2:0] x);
        return (x == 3'(NREQ - 1)) ? 3'd0 : x + 3'd1;
    endfunction

    // Winner is the requester closest to the pointer, counting upward with wrap.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_best  = NREQ;
        w_dist  = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_dist = k - int'(r_ptr);
            if (w_dist < 0) w_dist = w_dist + NREQ;
            if (bus.i_req[k] && (w_dist < w_best)) begin
                w_best  = w_dist;
                w_win   = 3'(k);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_win_last = 1'b0;
        w_own_req  = 1'b0;
        w_own_last = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (3'(k) == w_win) w_win_last = bus.i_req_last[k];
            if (3'(k) == r_owner) begin
                w_own_req  = bus.i_req[k];
                w_own_last = bus.i_req_last[k];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        w_sel       = r_owner;
        w_wr        = 1'b0;
`ifdef QUEUE2_ARB_TIMEOUT_EN
        w_idle_nxt  = r_idle;
        w_tmo_nxt   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                w_sel = w_win;
                if (w_found && !bus.i_q_full) begin
                    w_wr        = 1'b1;
                    w_owner_nxt = w_win;
                    if (w_win_last || (MAX_BURST == 1)) begin
                        w_ptr_nxt = f_inc(w_win);
                    end else begin
                        w_state_nxt = ST_LOCK;
                        w_cnt_nxt   = c_CW'(1);
`ifdef QUEUE2_ARB_TIMEOUT_EN
                        w_idle_nxt  = '0;
`endif
                    end
                end
            end
            ST_LOCK: begin
                if (w_own_req && !bus.i_q_full) begin
                    w_wr = 1'b1;
                    // The MAX_BURST-th beat closes the lock whatever its last flag says.
                    if (w_own_last || (r_cnt == c_CW'(MAX_BURST - 1))) begin
                        w_state_nxt = ST_IDLE;
                        w_ptr_nxt   = f_inc(r_owner);
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CW'(1);
                    end
                end
`ifdef QUEUE2_ARB_TIMEOUT_EN
                if (w_own_req) begin
                    w_idle_nxt = '0;
                end else if (!bus.i_q_full) begin
                    if (r_idle == c_TW'(TIMEOUT - 1)) begin
                        w_state_nxt = ST_IDLE;
                        w_ptr_nxt   = f_inc(r_owner);
                        w_cnt_nxt   = '0;
                        w_idle_nxt  = '0;
                        w_tmo_nxt   = 1'b1;
                    end else begin
                        w_idle_nxt = r_idle + c_TW'(1);
                    end
                end
`endif
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_gnt  = '0;
        w_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (3'(k) == w_sel) begin
                w_gnt[k] = w_wr;
                w_data   = bus.i_req_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_cnt   <= '0;
`ifdef QUEUE2_ARB_TIMEOUT_EN
            r_idle  <= '0;
            r_tmo   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
`ifdef QUEUE2_ARB_TIMEOUT_EN
            r_idle  <= w_idle_nxt;
            r_tmo   <= w_tmo_nxt;
`endif
        end
    end

    // Write strobes are masked by reset itself so they drop without waiting for a clock.
    assign bus.o_q_wr      = w_wr & i_rst_n;
    assign bus.o_gnt       = w_gnt & {NREQ{i_rst_n}};
    assign bus.o_q_wr_data = w_data;
    assign bus.o_busy      = (r_state == ST_LOCK);
    assign bus.o_owner     = r_owner;
`ifdef QUEUE2_ARB_TIMEOUT_EN
    assign bus.o_timeout   = r_tmo;
`else
    assign bus.o_timeout   = 1'b0;
`endif

endmodule

`default_nettype wire
